// File: rtl/piso_serializer_if.sv
// piso_serializer_if: word handshake and serial stream bundle for piso_serializer.
//   in_data/in_valid/in_ready/lsb_first : parallel word intake (valid/ready)
//   shift_en                            : bit-rate tick from upstream
//   ser_out/ser_frame/ser_last/busy     : serial stream and status
// master = word/tick source, slave = serializer.
interface piso_serializer_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             lsb_first;
  logic             shift_en;
  logic             ser_out;
  logic             ser_frame;
  logic             ser_last;
  logic             busy;

  modport master (
    output in_data, in_valid, lsb_first, shift_en,
    input  in_ready, ser_out, ser_frame, ser_last, busy
  );

  modport slave (
    input  in_data, in_valid, lsb_first, shift_en,
    output in_ready, ser_out, ser_frame, ser_last, busy
  );
endinterface

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in, serial-out transmitter with a one-entry
// holding buffer. Words enter over valid/ready, are shifted out one bit per
// shift_en tick in the per-word bit order, and frames run back-to-back when
// the buffer is refilled while a word is shifting.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : piso_serializer_if slave (word intake, shift tick, serial outputs)
//
// state  | meaning
// S_IDLE | no word on the line; loads the buffer as soon as it is full
// S_SHIFT| a word's bits are on ser_out; advances on shift_en
module piso_serializer #(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst,
  piso_serializer_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t           state, state_nxt;
  logic             hold_full;
  logic [WIDTH-1:0] hold_data;
  logic             hold_lsb;
  logic [WIDTH-1:0] sreg;
  logic             order_lsb;
  logic [CW-1:0]    count;
  logic             load;
  logic             shift;
  logic             accept;

  // in_ready comes straight from hold_full, so there is no path from in_valid.
  assign accept = bus.in_valid && !hold_full;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift     = 1'b0;
    case (state)
      S_IDLE: begin
        if (hold_full) begin
          load      = 1'b1;
          state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (bus.shift_en) begin
          if (count != '0) begin
            shift = 1'b1;
          end else if (hold_full) begin
            // Reload on the last bit's tick keeps the frame contiguous.
            load = 1'b1;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      hold_full <= 1'b0;
      hold_data <= '0;
      hold_lsb  <= 1'b0;
      sreg      <= '0;
      order_lsb <= 1'b0;
      count     <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        sreg      <= hold_data;
        order_lsb <= hold_lsb;
        count     <= CW'(WIDTH - 1);
        hold_full <= 1'b0;
      end else if (shift) begin
        sreg  <= order_lsb ? (sreg >> 1) : (sreg << 1);
        count <= count - CW'(1);
      end
      // Cannot coincide with load: accept needs hold_full low.
      if (accept) begin
        hold_data <= bus.in_data;
        hold_lsb  <= bus.lsb_first;
        hold_full <= 1'b1;
      end
    end
  end

  assign bus.in_ready  = !hold_full;
  assign bus.ser_frame = (state == S_SHIFT);
  assign bus.ser_out   = (state == S_SHIFT) && (order_lsb ? sreg[0] : sreg[WIDTH-1]);
  assign bus.ser_last  = (state == S_SHIFT) && (count == '0);
  assign bus.busy      = (state == S_SHIFT) || hold_full;

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed bench for piso_serializer (WIDTH=8) with a
// queue-of-bits reference model checked every cycle, plus literal stream checks.
module tb_piso_serializer;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  piso_serializer_if #(.WIDTH(W)) bus ();

  piso_serializer #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s timeout actual=no_event expected=event at %0t", name, $time);
  endtask

  // Reference model: the pending bits of the word on the line, in send order,
  // plus the one-entry buffer.
  logic         m_hold_v;
  logic [W-1:0] m_hold_d;
  logic         m_hold_l;
  logic         m_bits[$];

  function automatic void m_load();
    for (int i = 0; i < W; i++)
      m_bits.push_back(m_hold_l ? m_hold_d[i] : m_hold_d[W-1-i]);
    m_hold_v = 1'b0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_hold_v = 1'b0;
      m_hold_d = '0;
      m_hold_l = 1'b0;
      m_bits.delete();
    end else begin
      logic acc;
      acc = bus.in_valid && !m_hold_v;
      if (m_bits.size() != 0) begin
        if (bus.shift_en) begin
          m_bits.delete(0);
          if (m_bits.size() == 0 && m_hold_v) m_load();
        end
      end else if (m_hold_v) begin
        m_load();
      end
      if (acc) begin
        m_hold_v = 1'b1;
        m_hold_d = bus.in_data;
        m_hold_l = bus.lsb_first;
      end
    end
  end

  // Per-cycle compare and stream recording.
  logic rec_dut[$];
  logic rec_mod[$];
  int   frame_cyc, last_cyc, run, max_run;

  always @(negedge clk) begin
    if (!rst) begin
      logic e_frame;
      e_frame = (m_bits.size() != 0);
      chk("cyc_in_ready",  {31'd0, bus.in_ready},  {31'd0, !m_hold_v});
      chk("cyc_ser_frame", {31'd0, bus.ser_frame}, {31'd0, e_frame});
      chk("cyc_ser_out",   {31'd0, bus.ser_out},   {31'd0, e_frame ? m_bits[0] : 1'b0});
      chk("cyc_ser_last",  {31'd0, bus.ser_last},  {31'd0, m_bits.size() == 1});
      chk("cyc_busy",      {31'd0, bus.busy},      {31'd0, e_frame || m_hold_v});
      if (bus.ser_frame && bus.shift_en) rec_dut.push_back(bus.ser_out);
      if (e_frame && bus.shift_en) rec_mod.push_back(m_bits[0]);
      if (bus.ser_frame) begin
        frame_cyc++;
        run++;
      end else if (run > 0) begin
        if (run > max_run) max_run = run;
        run = 0;
      end
      if (bus.ser_last) last_cyc++;
    end
  end

  // shift_en driver: constant high, or high every third cycle.
  int se_mode = 0;
  int se_div  = 0;
  always @(posedge clk) begin
    #1;
    if (se_mode == 0) begin
      bus.shift_en = 1'b1;
    end else begin
      se_div++;
      bus.shift_en = (se_div % 3 == 0);
    end
  end

  task automatic rec_clear();
    rec_dut.delete();
    rec_mod.delete();
    frame_cyc = 0;
    last_cyc  = 0;
    run       = 0;
    max_run   = 0;
  endtask

  task automatic send(input logic [W-1:0] d, input logic lsb);
    bit done;
    done = 1'b0;
    bus.in_data   = d;
    bus.lsb_first = lsb;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      if (bus.in_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!done) timeout("send");
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (!bus.busy) done = 1'b1;
    end
    if (!done) timeout("wait_idle");
    @(posedge clk);
    #1;
  endtask

  task automatic check_stream(input string name, input int n, input logic [31:0] exp);
    logic [31:0] vd, vm;
    vd = '0;
    vm = '0;
    foreach (rec_dut[i]) vd = {vd[30:0], rec_dut[i]};
    foreach (rec_mod[i]) vm = {vm[30:0], rec_mod[i]};
    chk({name, "_nbits"}, rec_dut.size(), n);
    chk({name, "_dut"}, vd, exp);
    chk({name, "_model"}, vm, exp);
  endtask

  initial begin
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.lsb_first = 1'b0;
    bus.shift_en  = 1'b0;
    rec_clear();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Idle after reset; shift_en high has no effect.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_in_ready",  {31'd0, bus.in_ready},  32'd1);
      chk("idle_ser_out",   {31'd0, bus.ser_out},   32'd0);
      chk("idle_ser_frame", {31'd0, bus.ser_frame}, 32'd0);
      chk("idle_busy",      {31'd0, bus.busy},      32'd0);
    end
    @(posedge clk);
    #1;

    rec_clear();
    send(8'hA5, 1'b0);
    wait_idle();
    check_stream("a5_msb", 8, 32'hA5);
    chk("a5_msb_frame_cyc", frame_cyc, 8);
    chk("a5_msb_last_cyc", last_cyc, 1);

    rec_clear();
    send(8'hA5, 1'b1);
    wait_idle();
    check_stream("a5_lsb", 8, 32'hA5);

    rec_clear();
    send(8'h01, 1'b1);
    wait_idle();
    check_stream("01_lsb", 8, 32'h80);

    // Back-to-back: second word offered while the first is shifting.
    rec_clear();
    send(8'hF0, 1'b0);
    send(8'h0F, 1'b1);
    wait_idle();
    check_stream("b2b", 16, 32'hF0F0);
    chk("b2b_max_run", max_run, 16);
    chk("b2b_last_cyc", last_cyc, 2);

    // shift_en every third cycle.
    rec_clear();
    se_mode = 1;
    se_div  = 0;
    send(8'hC3, 1'b0);
    wait_idle();
    check_stream("c3_div3", 8, 32'hC3);
    chk("c3_last_cyc", last_cyc, 3);
    se_mode = 0;
    @(posedge clk);
    #1;

    // Reset mid-frame with a word buffered.
    rec_clear();
    send(8'hFF, 1'b0);
    begin
      bit done;
      done = 1'b0;
      for (int i = 0; i < 50 && !done; i++) begin
        @(posedge clk);
        #1;
        if (rec_dut.size() >= 3) done = 1'b1;
      end
      if (!done) timeout("rst_wait_bits");
    end
    send(8'h55, 1'b0);
    chk("rst_pre_hold_busy", {31'd0, bus.busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    chk("rst_ser_out",   {31'd0, bus.ser_out},   32'd0);
    chk("rst_ser_frame", {31'd0, bus.ser_frame}, 32'd0);
    chk("rst_ser_last",  {31'd0, bus.ser_last},  32'd0);
    chk("rst_busy",      {31'd0, bus.busy},      32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_frame", {31'd0, bus.ser_frame}, 32'd0);
      chk("post_rst_ready", {31'd0, bus.in_ready},  32'd1);
      chk("post_rst_busy",  {31'd0, bus.busy},      32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
